// File: rtl/vga_rx.sv
`default_nettype none
// ============================================================================
// Module   : vga_rx
// Brief    : VGA (hsync/vsync + 4:4:4 RGB) capture front end. Extracts the
//            active window of each frame and streams it out over AXI-Stream
//            through a small pixel FIFO, flagging overflow and short lines.
// Revision : 1.0 - initial release
// ============================================================================
module vga_rx #(
    parameter int FIFO_DEPTH = 16
) (
    input  logic        aclk,
    input  logic        aresetn,
    input  logic        enable,
    input  logic        vga_hsync,
    input  logic        vga_vsync,
    input  logic [3:0]  vga_r,
    input  logic [3:0]  vga_g,
    input  logic [3:0]  vga_b,
    input  logic [15:0] H_RES,
    input  logic [15:0] H_BACK_PORCH,
    input  logic [15:0] V_RES,
    input  logic [15:0] V_BACK_PORCH,
    output logic        pix_tvalid,
    input  logic        pix_tready,
    output logic [11:0] pix_tdata,
    output logic        pix_tlast,
    output logic        pix_tuser,
    output logic        overflow,
    output logic        line_err,
    input  logic        clear
);

    localparam int             AW      = $clog2(FIFO_DEPTH);
    localparam logic [AW:0]    DEPTH_C = (AW+1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {H_SYNC, H_BP, H_PIX, H_DONE} h_state_t;
    typedef enum logic [1:0] {V_IDLE, V_WAIT, V_ACTIVE}    v_state_t;

    // Input sampling registers
    logic        primed_q;
    logic        hs_q, vs_q, hs_prev_q, vs_prev_q;
    logic [11:0] rgb_q;

    // Timing state
    h_state_t    h_q, h_d;
    v_state_t    v_q, v_d;
    logic [16:0] hcnt_q, hcnt_d;
    logic [15:0] vcnt_q, vcnt_d;

    // FIFO and flags
    logic [13:0] mem_q [FIFO_DEPTH];
    logic [AW:0] wptr_q, rptr_q;
    logic        overflow_q, overflow_d;
    logic        line_err_q, line_err_d;

    // Combinational helpers
    logic        w_hs_fall, w_hs_rise, w_vs_rise;
    logic [16:0] w_h_bp, w_h_end, w_v_bp, w_v_end;
    logic        w_in_line;
    logic [16:0] w_k, w_k_next;
    logic        w_line_act, w_cap, w_tlast, w_tuser, w_lerr;
    logic [AW:0] w_count;
    logic        w_full, w_rd, w_wr, w_drop;
    logic [13:0] w_rd_word;

    // Sample the VGA pins once; on the first clock after reset the previous
    // sample is loaded with the pin value so no false edge appears.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            primed_q  <= 1'b0;
            hs_q      <= 1'b0;
            vs_q      <= 1'b0;
            hs_prev_q <= 1'b0;
            vs_prev_q <= 1'b0;
            rgb_q     <= 12'd0;
        end else begin
            primed_q  <= 1'b1;
            hs_q      <= vga_hsync;
            vs_q      <= vga_vsync;
            rgb_q     <= {vga_b, vga_g, vga_r};
            hs_prev_q <= primed_q ? hs_q : vga_hsync;
            vs_prev_q <= primed_q ? vs_q : vga_vsync;
        end
    end

    assign w_hs_fall = hs_prev_q & ~hs_q;
    assign w_hs_rise = ~hs_prev_q & hs_q;
    assign w_vs_rise = ~vs_prev_q & vs_q;

    assign w_h_bp  = {1'b0, H_BACK_PORCH};
    assign w_h_end = {1'b0, H_BACK_PORCH} + {1'b0, H_RES};
    assign w_v_bp  = {1'b0, V_BACK_PORCH};
    assign w_v_end = {1'b0, V_BACK_PORCH} + {1'b0, V_RES};

    // Horizontal position tracking; w_k is the port-cycle index of the pixel now in rgb_q
    always_comb begin
        h_d       = h_q;
        hcnt_d    = hcnt_q;
        w_in_line = ((h_q == H_SYNC) && w_hs_rise) || (h_q == H_BP) || (h_q == H_PIX);
        w_k       = (h_q == H_SYNC) ? 17'd0 : hcnt_q;
        w_k_next  = w_k + 17'd1;
        if (w_hs_fall) begin
            h_d = H_SYNC;
        end else if (w_in_line) begin
            hcnt_d = w_k_next;
            if (w_k_next < w_h_bp) begin
                h_d = H_BP;
            end else if (w_k_next < w_h_end) begin
                h_d = H_PIX;
            end else begin
                h_d = H_DONE;
            end
        end
    end

    // Line counting and frame arming; mode changes only take effect at line boundaries
    always_comb begin
        v_d    = v_q;
        vcnt_d = vcnt_q;
        if (w_vs_rise) begin
            vcnt_d = 16'd0;
        end else if (w_hs_fall && (vcnt_q != 16'hFFFF)) begin
            vcnt_d = vcnt_q + 16'd1;
        end
        case (v_q)
            V_IDLE: begin
                if (enable) v_d = V_WAIT;
            end
            V_WAIT: begin
                if (w_hs_fall && !enable)  v_d = V_IDLE;
                else if (w_vs_rise)        v_d = V_ACTIVE;
            end
            V_ACTIVE: begin
                if (w_hs_fall && !enable)                          v_d = V_IDLE;
                else if (w_hs_fall && ({1'b0, vcnt_d} >= w_v_end)) v_d = V_WAIT;
            end
            default: v_d = V_IDLE;
        endcase
    end

    assign w_line_act = ({1'b0, vcnt_q} >= w_v_bp) && ({1'b0, vcnt_q} < w_v_end);
    assign w_cap      = (v_q == V_ACTIVE) && w_line_act && w_in_line && !w_hs_fall
                        && (w_k >= w_h_bp) && (w_k < w_h_end);
    assign w_tlast    = (w_k == (w_h_end - 17'd1));
    assign w_tuser    = (w_k == w_h_bp) && (vcnt_q == V_BACK_PORCH);
    assign w_lerr     = w_hs_fall && ((h_q == H_BP) || (h_q == H_PIX))
                        && (v_q == V_ACTIVE) && w_line_act;

    // FIFO bookkeeping: a read on a full FIFO frees the slot for the same-cycle write
    assign w_count    = wptr_q - rptr_q;
    assign w_full     = (w_count == DEPTH_C);
    assign pix_tvalid = (wptr_q != rptr_q);
    assign w_rd       = pix_tvalid & pix_tready;
    assign w_wr       = w_cap & (~w_full | w_rd);
    assign w_drop     = w_cap & w_full & ~w_rd;

    assign w_rd_word  = mem_q[rptr_q[AW-1:0]];
    assign pix_tdata  = pix_tvalid ? w_rd_word[11:0] : 12'd0;
    assign pix_tlast  = pix_tvalid & w_rd_word[12];
    assign pix_tuser  = pix_tvalid & w_rd_word[13];
    assign overflow   = overflow_q;
    assign line_err   = line_err_q;

    // Sticky flags: a new event in the same cycle as clear wins
    always_comb begin
        overflow_d = (clear ? 1'b0 : overflow_q) | w_drop;
        line_err_d = (clear ? 1'b0 : line_err_q) | w_lerr;
    end

    // Pixel storage; contents are don't-care until the write pointer passes them
    always_ff @(posedge aclk) begin
        if (w_wr) mem_q[wptr_q[AW-1:0]] <= {w_tuser, w_tlast, rgb_q};
    end

    // State, counters, pointers and flags
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            h_q        <= H_SYNC;
            v_q        <= V_IDLE;
            hcnt_q     <= 17'd0;
            vcnt_q     <= 16'd0;
            wptr_q     <= '0;
            rptr_q     <= '0;
            overflow_q <= 1'b0;
            line_err_q <= 1'b0;
        end else begin
            h_q        <= h_d;
            v_q        <= v_d;
            hcnt_q     <= hcnt_d;
            vcnt_q     <= vcnt_d;
            overflow_q <= overflow_d;
            line_err_q <= line_err_d;
            if (w_wr) wptr_q <= wptr_q + 1'b1;
            if (w_rd) rptr_q <= rptr_q + 1'b1;
        end
    end

endmodule
`default_nettype wire
